// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and helpers for the key debouncer.
// Holds the per-channel FSM state enum and the counter width function.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_e;

    // Width that holds the largest cycle count among the three timers.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one debounced key channel with optional auto-repeat.
// Ports: i_clk, i_rst_n (async low), i_raw (raw level), o_level (1 = pressed),
//        o_press / o_release (1-cycle pulses), o_repeat (press is a repeat).
module key_debounce_ch #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_PER   = 5000000,
    parameter int CW           = 25
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);
    import key_debounce_pkg::*;

    localparam logic            RAW_IDLE = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0]   DB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0]   DLY_LAST = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0]   PER_LAST = CW'(REPEAT_PER - 1);
    localparam logic [CW-1:0]   CNT_MAX  = '1;

    logic          sync_q1, sync_q2;
    logic          s;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          first_q, first_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          rep_q, rep_d;
    logic [CW-1:0] cnt_inc, rcnt_inc, rep_last;

    // Synchroniser resets to the idle raw level so reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q1 <= RAW_IDLE;
            sync_q2 <= RAW_IDLE;
        end else begin
            sync_q1 <= i_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign s = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            first_q <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rep_q   <= rep_d;
        end
    end

    // Counters saturate instead of wrapping.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign rcnt_inc = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + CW'(1);
    // first_q selects the long initial delay before the first repeat.
    assign rep_last = first_q ? DLY_LAST : PER_LAST;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        first_d = first_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        rep_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rcnt_d  = '0;
                first_d = 1'b1;
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    // Repeat counter is left untouched: it pauses here.
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (rcnt_q == rep_last) begin
                        press_d = 1'b1;
                        rep_d   = 1'b1;
                        rcnt_d  = '0;
                        first_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt_inc;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    state_d = ST_HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    rel_d   = 1'b1;
                    rcnt_d  = '0;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_level   = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
        o_press   = press_q;
        o_release = rel_q;
        o_repeat  = (REPEAT_EN != 0) ? rep_q : 1'b0;
    end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: N_CH independent key debouncers with optional auto-repeat.
// Ports: i_clk, i_rst_n (async low), i_raw[N_CH], o_level, o_press,
//        o_release, o_repeat (all N_CH wide, one bit per channel).
module key_debounce #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_PER   = 5000000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_raw,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_repeat
);
    import key_debounce_pkg::*;

    localparam int CW = cnt_width(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER);

    if (N_CH < 1 || DEBOUNCE_CYC < 1 || REPEAT_DLY < 1 ||
        REPEAT_PER < 1) begin : g_bad_param
        $error("key_debounce: illegal parameter value");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DLY   (REPEAT_DLY),
            .REPEAT_PER   (REPEAT_PER),
            .CW           (CW)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_raw     (i_raw[i]),
            .o_level   (o_level[i]),
            .o_press   (o_press[i]),
            .o_release (o_release[i]),
            .o_repeat  (o_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: random + directed scoreboard bench for key_debounce.
// A run-length reference model queues expected pulses; a monitor checks them.
module tb_key_debounce;

    localparam int NCH  = 4;
    localparam int DB   = 8;
    localparam int RDLY = 20;
    localparam int RPER = 5;
    localparam int REN  = 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] raw = '1;
    logic [NCH-1:0] o_level, o_press, o_release, o_repeat;

    key_debounce #(
        .N_CH         (NCH),
        .DEBOUNCE_CYC (DB),
        .ACTIVE_LOW   (1),
        .REPEAT_EN    (REN),
        .REPEAT_DLY   (RDLY),
        .REPEAT_PER   (RPER)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_raw     (raw),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_repeat  (o_repeat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always_ff @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] pr;
        logic [NCH-1:0] rl;
        logic [NCH-1:0] rp;
    } ev_t;

    ev_t sbq[$];

    // Reference model state: pressed-level history, accepted level,
    // run of disagreeing samples, cycles spent held for auto-repeat.
    logic [NCH-1:0] h1, h2, m_lvl;
    int run[NCH];
    int elapsed[NCH];

    int last_press_cyc[NCH];
    int last_rel_cyc[NCH];
    int first_rep_cyc[NCH];
    int press_cnt[NCH];
    int rel_cnt[NCH];
    int rep_cnt[NCH];
    logic [NCH-1:0] last_press_vec;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic model_reset();
        h1 = '0;
        h2 = '0;
        m_lvl = '0;
        for (int c = 0; c < NCH; c++) begin
            run[c] = 0;
            elapsed[c] = 0;
        end
        sbq.delete();
    endtask

    // Model: a level is accepted once DB+1 consecutive synchronised
    // samples disagree with it; repeats fire at RDLY, RDLY+RPER, ...
    // counted over cycles spent steadily held.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                ev_t e;
                logic [NCH-1:0] s;
                e.pr = '0;
                e.rl = '0;
                e.rp = '0;
                s  = h2;
                h2 = h1;
                h1 = ~raw;
                for (int c = 0; c < NCH; c++) begin
                    if (s[c] != m_lvl[c]) begin
                        run[c]++;
                        if (run[c] == DB + 1) begin
                            m_lvl[c]   = s[c];
                            run[c]     = 0;
                            elapsed[c] = 0;
                            if (s[c]) e.pr[c] = 1'b1;
                            else      e.rl[c] = 1'b1;
                        end
                    end else begin
                        if (m_lvl[c] && run[c] == 0 && REN != 0) begin
                            elapsed[c]++;
                            if (elapsed[c] == RDLY ||
                                (elapsed[c] > RDLY &&
                                 (elapsed[c] - RDLY) % RPER == 0)) begin
                                e.pr[c] = 1'b1;
                                e.rp[c] = 1'b1;
                            end
                        end
                        run[c] = 0;
                    end
                end
                if ((e.pr | e.rl | e.rp) != '0) begin
                    e.cyc = cyc + 1;
                    sbq.push_back(e);
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT pulses or one is due.
    initial begin
        for (int c = 0; c < NCH; c++) begin
            last_press_cyc[c] = -1;
            last_rel_cyc[c]   = -1;
            first_rep_cyc[c]  = -1;
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
            rep_cnt[c]   = 0;
        end
        last_press_vec = '0;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_event: got none expected pulse at cycle %0d",
                         sbq[0].cyc);
                void'(sbq.pop_front());
            end
            chk("level", int'(o_level), int'(m_lvl));
            if ((o_press | o_release | o_repeat) != '0 ||
                (sbq.size() > 0 && sbq[0].cyc == cyc)) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got p=%b r=%b rp=%b expected none (cycle %0d)",
                             o_press, o_release, o_repeat, cyc);
                end else begin
                    ev_t e;
                    e = sbq.pop_front();
                    chk("event_cyc", cyc, e.cyc);
                    chk("press_vec", int'(o_press), int'(e.pr));
                    chk("release_vec", int'(o_release), int'(e.rl));
                    chk("repeat_vec", int'(o_repeat), int'(e.rp));
                end
            end
            if (o_press != '0) last_press_vec = o_press;
            for (int c = 0; c < NCH; c++) begin
                if (o_press[c]) begin
                    last_press_cyc[c] = cyc;
                    press_cnt[c]++;
                end
                if (o_release[c]) begin
                    last_rel_cyc[c] = cyc;
                    rel_cnt[c]++;
                end
                if (o_repeat[c]) begin
                    rep_cnt[c]++;
                    if (first_rep_cyc[c] < 0) first_rep_cyc[c] = cyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int e0, p0, r0, q0;
        bit slow;
        raw   = '1;
        rst_n = 1'b0;
        tick(3);
        chk("rst_level", int'(o_level), 0);
        chk("rst_press", int'(o_press), 0);
        chk("rst_release", int'(o_release), 0);
        chk("rst_repeat", int'(o_repeat), 0);
        rst_n = 1'b1;
        tick(5);

        // Clean press on channel 0.
        raw[0] = 1'b0;
        e0 = cyc + 1;
        tick(20);
        chk("clean_press_cyc", last_press_cyc[0], e0 + DB + 2);
        chk("clean_level", int'(o_level[0]), 1);

        // Release on channel 0.
        raw[0] = 1'b1;
        e0 = cyc + 1;
        tick(20);
        chk("release_cyc", last_rel_cyc[0], e0 + DB + 2);
        chk("release_level", int'(o_level[0]), 0);

        // Bounce on channel 1.
        p0 = press_cnt[1];
        raw[1] = 1'b0;
        tick(5);
        raw[1] = 1'b1;
        tick(1);
        raw[1] = 1'b0;
        e0 = cyc + 1;
        tick(20);
        chk("bounce_press_cyc", last_press_cyc[1], e0 + DB + 2);
        chk("bounce_press_cnt", press_cnt[1] - p0, 1);
        chk("bounce_no_release", rel_cnt[1], 0);
        raw[1] = 1'b1;
        tick(15);

        // Auto-repeat on channel 2: 60-cycle hold.
        p0 = press_cnt[2];
        r0 = rep_cnt[2];
        first_rep_cyc[2] = -1;
        raw[2] = 1'b0;
        e0 = cyc + 1;
        tick(60);
        raw[2] = 1'b1;
        tick(15);
        chk("repeat_first_cyc", first_rep_cyc[2], e0 + DB + 2 + RDLY);
        chk("repeat_cnt", rep_cnt[2] - r0, 7);
        chk("repeat_press_cnt", press_cnt[2] - p0, 8);

        // Simultaneous fall on all channels.
        raw = '0;
        e0 = cyc + 1;
        tick(12);
        chk("simul_vec", int'(last_press_vec), 15);
        chk("simul_cyc0", last_press_cyc[0], e0 + DB + 2);
        chk("simul_cyc3", last_press_cyc[3], e0 + DB + 2);
        raw = '1;
        tick(15);

        // Reset at count 4 of the press wait on channel 0, key kept held.
        q0 = rel_cnt[0];
        raw[0] = 1'b0;
        tick(7);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", int'(o_level), 0);
        chk("midrst_press", int'(o_press), 0);
        chk("midrst_release", int'(o_release), 0);
        chk("midrst_repeat", int'(o_repeat), 0);
        tick(3);
        rst_n = 1'b1;
        e0 = cyc + 1;
        tick(14);
        chk("midrst_press_cyc", last_press_cyc[0], e0 + DB + 2);
        chk("midrst_no_release", rel_cnt[0] - q0, 0);
        raw[0] = 1'b1;
        tick(15);

        // Random phase: alternating bouncy and slow segments, rare resets.
        slow = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) slow = ~slow;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, slow ? 45 : 4) == 0) raw[c] = ~raw[c];
            end
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_out", int'(o_level | o_press | o_release | o_repeat), 0);
                tick(2);
                rst_n = 1'b1;
            end
            tick(1);
        end
        raw = '1;
        tick(40);
        chk("sb_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 1000000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); legal range >=1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means a raw 0 is "pressed"; 0 means a raw 1 is "pressed".
REQ-004 SHALL have parameter REPEAT_EN, default 0: 1 enables auto-repeat.
REQ-005 SHALL have parameter REPEAT_DLY, default 25000000: cycles from the initial press pulse to the first repeat; legal range >=1.
REQ-006 SHALL have parameter REPEAT_PER, default 5000000: cycles between later repeats; legal range >=1.
REQ-007 SHALL have i_clk  input  1  sole clock, rising edge.
REQ-008 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have i_raw  input  N_CH  raw asynchronous key/switch levels.
REQ-010 SHALL have o_level  output  N_CH  debounced state per channel, 1 = pressed.
REQ-011 SHALL have o_press  output  N_CH  one-cycle pulse on an accepted press and on each repeat.
REQ-012 SHALL have o_release  output  N_CH  one-cycle pulse on an accepted release.
REQ-013 SHALL have o_repeat  output  N_CH  high only in cycles where o_press is caused by auto-repeat.

Function
REQ-014 Each channel SHALL pass i_raw through a 2-flop synchroniser, then apply ACTIVE_LOW polarity to form s (1 = pressed).
REQ-015 Each channel SHALL have an FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-016 IDLE, s=1: go to PRESS_WAIT and clear the stable counter.
REQ-017 PRESS_WAIT: count cycles with s=1; s=0 SHALL return to IDLE with no pulse.
REQ-018 PRESS_WAIT, count reaching DEBOUNCE_CYC: go to HELD, set o_level=1, pulse o_press.
REQ-019 HELD, s=0: go to RELEASE_WAIT, mirroring REQ-017 and REQ-018.
REQ-020 RELEASE_WAIT, s=1 before the count completes: return to HELD, no pulse, o_level stays 1.
REQ-021 RELEASE_WAIT, count completing: go to IDLE, set o_level=0, pulse o_release.
REQ-022 Latency SHALL be exactly 2+DEBOUNCE_CYC cycles from the first edge sampling a new held raw level to the pulse and o_level change.
REQ-023 A glitch shorter than DEBOUNCE_CYC cycles SHALL produce no pulse and no o_level change.
REQ-024 With REPEAT_EN=1, a repeat counter SHALL run in HELD: first repeat REPEAT_DLY cycles after the initial o_press, then every REPEAT_PER cycles.
REQ-025 Each repeat SHALL assert o_press and o_repeat together for one cycle.
REQ-026 The repeat counter SHALL pause in RELEASE_WAIT, resume on return to HELD, and clear on entry to IDLE.
REQ-027 With REPEAT_EN=0, o_repeat SHALL be constant 0.
REQ-028 o_press and o_release SHALL never be high in the same cycle on the same channel.
REQ-029 Channels SHALL be fully independent; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.
REQ-030 Counters SHALL saturate and never wrap; widths SHALL be $clog2 of max(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER)+1.
REQ-031 Illegal parameter values SHALL be rejected by an elaboration-time assertion.

Reset
REQ-032 Asserting i_rst_n low, at any time including mid-count, SHALL immediately force: o_level, o_press, o_release and o_repeat to 0; all states to IDLE; counters to 0; synchroniser flops to the inactive raw level (1 if ACTIVE_LOW).
REQ-033 A key held through reset release SHALL produce o_press 2+DEBOUNCE_CYC cycles after the first edge following release, and no spurious o_release.

Structure
REQ-034 Package key_debounce_pkg SHALL hold the FSM state enum and a width-calculation function.
REQ-035 Sub-module key_debounce_ch SHALL implement one channel; key_debounce SHALL instantiate N_CH copies through a generate loop.

Verification (DEBOUNCE_CYC=8, REPEAT_DLY=20, REPEAT_PER=5, ACTIVE_LOW=1, N_CH=4)
REQ-036 Clean press: i_raw[0] 1->0 and held -> o_press[0] pulses once 10 cycles later; o_level[0]=1 from that cycle.
REQ-037 Bounce: i_raw[1] low 5 cycles, high 1 cycle, low 20 cycles -> exactly one o_press[1], 10 cycles after the final fall; no o_release[1].
REQ-038 Repeat with REPEAT_EN=1: hold i_raw[2] low 60 cycles -> o_press[2] pulses at t0, t0+20, t0+25, t0+30, ...; o_repeat[2] high on all but t0.
REQ-039 Release: raise i_raw[0] after it is accepted pressed -> o_release[0] pulses 10 cycles later; o_level[0]=0.
REQ-040 Mid-count reset: assert i_rst_n at count 4 of PRESS_WAIT -> all outputs 0 immediately; with the key still held, o_press 10 cycles after reset release.
REQ-041 Simultaneous events: all four i_raw lines fall on the same cycle -> o_press=4'b1111 in one cycle, 10 cycles later.
